// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one divider among NUM_REQ clients.
// Ports: req_* (in), rsp_* (out), div_* (divider link), busy, grant_id.
// Optional: DIV_ARB_ZERO_CHECK_EN answers x/0 without using the divider.
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_err,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_done,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rq_q, rq_d;
  logic [WIDTH-1:0] rr_q, rr_d;
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] win_a, win_b;

  // Rotating search: first valid at or above ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign win_a = req_dividend[win*WIDTH +: WIDTH];
  assign win_b = req_divisor[win*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    rq_d      = rq_q;
    rr_d      = rr_q;
    err_d     = err_q;
    start_d   = 1'b0;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          gid_d = win;
          opa_d = win_a;
          opb_d = win_b;
          ptr_d = (win == IDW'(NUM_REQ-1)) ? '0
                                           : win + 1'b1;
`ifdef DIV_ARB_ZERO_CHECK_EN
          if (win_b == '0) begin
            state_d = S_RESP;
            rq_d    = '1;
            rr_d    = win_a;
            err_d   = 1'b1;
          end else begin
            state_d = S_LAUNCH;
            start_d = 1'b1;
          end
`else
          state_d = S_LAUNCH;
          start_d = 1'b1;
`endif
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          rq_d    = div_quotient;
          rr_d    = div_remainder;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready[gid_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rq_q    <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rq_q    <= rq_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[gid_q] = 1'b1;
  end

  assign rsp_quotient  = rq_q;
  assign rsp_remainder = rr_q;
  assign rsp_err       = err_q;
  assign div_start     = start_q;
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed vectors plus arbitration/backpressure/reset
// sequences against a behavioural multi-cycle divider model.
`timescale 1ns/1ps
module tb_div_arbiter;
  localparam int N = 4;
  localparam int W = 16;
`ifdef DIV_ARB_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dividend = '0;
  logic [N*W-1:0]   req_divisor = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '1;
  logic [W-1:0]     rsp_quotient, rsp_remainder;
  logic             rsp_err, div_start, div_done, busy;
  logic [W-1:0]     div_dividend, div_divisor;
  logic [W-1:0]     div_quotient, div_remainder;
  logic [1:0]       grant_id;
  logic             mdl_done = 1'b0;
  logic             man_done = 1'b0;
  int               lat = 10;
  int               dcnt = 0;
  int               n_chk = 0;
  int               n_fail = 0;
  int               gord[8];
  int               gcyc[8];
  int               ng;
  logic [W-1:0]     eq[N];
  logic [W-1:0]     er[N];

  div_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  assign div_done      = mdl_done | man_done;
  assign div_quotient  = (div_divisor == 0) ? '1
                                            : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == 0) ? div_dividend
                                            : div_dividend % div_divisor;

  always @(posedge clock) begin
    if (reset) begin
      dcnt     <= 0;
      mdl_done <= 1'b0;
    end else begin
      mdl_done <= 1'b0;
      if (div_start) begin
        if (lat == 0) mdl_done <= 1'b1;
        else dcnt <= lat;
      end else if (dcnt == 1) begin
        dcnt     <= 0;
        mdl_done <= 1'b1;
      end else if (dcnt > 1) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t tv[7];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(int id, logic [W-1:0] a, logic [W-1:0] b);
    req_dividend[id*W +: W] = a;
    req_divisor[id*W +: W]  = b;
    eq[id] = (b == 0) ? '1 : a / b;
    er[id] = (b == 0) ? a : a % b;
  endtask

  task automatic chk_zero(string nm);
    chk(nm, {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
             div_start, div_dividend, div_divisor, busy, grant_id}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic arb_run(input logic [N-1:0] vmask,
                         input logic [N-1:0] sticky,
                         input int nresp);
    int cyc;
    int nr;
    logic [N-1:0] acc;
    cyc = 0;
    nr  = 0;
    ng  = 0;
    req_valid = vmask;
    while (nr < nresp && cyc < 300) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          chk("arb_q", rsp_quotient, eq[i]);
          chk("arb_r", rsp_remainder, er[i]);
          nr++;
        end
      end
      acc = req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && ng < 8) begin
          gord[ng] = i;
          gcyc[ng] = cyc;
          ng++;
        end
      end
      step();
      req_valid = req_valid & ~(acc & ~sticky);
      cyc++;
    end
    req_valid = '0;
    chk("arb_nresp", nr, nresp);
  endtask

  initial begin
    int c;
    logic xz;
    tv[0] = '{0, 16'd100,   16'd7,    16'd14,    16'd2};
    tv[1] = '{1, 16'd50,    16'd5,    16'd10,    16'd0};
    tv[2] = '{2, 16'd9,     16'd4,    16'd2,     16'd1};
    tv[3] = '{3, 16'd65535, 16'd1,    16'd65535, 16'd0};
    tv[4] = '{0, 16'd3,     16'd10,   16'd0,     16'd3};
    tv[5] = '{2, 16'd37,    16'd0,    16'hFFFF,  16'd37};
    tv[6] = '{1, 16'd1234,  16'd1234, 16'd1,     16'd0};

    step();
    @(negedge clock);
    chk_zero("reset_state");
    do_reset();

    for (int i = 0; i < 7; i++) begin
      lat = 10;
      xz = ZC && (tv[i].b == 0);
      set_op(tv[i].id, tv[i].a, tv[i].b);
      req_valid[tv[i].id] = 1'b1;
      c = 0;
      @(negedge clock);
      while (req_ready == 0 && c < 20) begin
        @(negedge clock);
        c++;
      end
      chk("vec_req_ready", req_ready, 64'd1 << tv[i].id);
      step();
      req_valid = '0;
      @(negedge clock);
      chk("vec_div_start", div_start, !xz);
      chk("vec_grant_id", grant_id, tv[i].id);
      chk("vec_busy", busy, 1);
      if (!xz) begin
        chk("vec_opa", div_dividend, tv[i].a);
        chk("vec_opb", div_divisor, tv[i].b);
      end else begin
        chk("vec_zero_t1", rsp_valid, 64'd1 << tv[i].id);
      end
      c = 0;
      while (rsp_valid == 0 && c < 40) begin
        @(negedge clock);
        c++;
      end
      chk("vec_rsp_valid", rsp_valid, 64'd1 << tv[i].id);
      chk("vec_q", rsp_quotient, tv[i].q);
      chk("vec_r", rsp_remainder, tv[i].r);
      chk("vec_err", rsp_err, xz);
      @(posedge clock);
      @(negedge clock);
      chk("vec_busy_low", busy, 0);
    end

    // All four from reset, immediate divider: order 0..3, 4-cycle pitch.
    do_reset();
    lat = 0;
    set_op(0, 16'd100, 16'd7);
    set_op(1, 16'd50, 16'd5);
    set_op(2, 16'd9, 16'd4);
    set_op(3, 16'd77, 16'd8);
    arb_run(4'b1111, 4'b0000, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", gord[i], i);
      if (i > 0) chk("rr_pitch", gcyc[i] - gcyc[i-1], 4);
    end

    // Requester 1 always asking, 3 waiting: 1, 3, 1.
    do_reset();
    lat = 2;
    set_op(1, 16'd81, 16'd9);
    set_op(3, 16'd20, 16'd3);
    arb_run(4'b1010, 4'b0010, 3);
    chk("fair_0", gord[0], 1);
    chk("fair_1", gord[1], 3);
    chk("fair_2", gord[2], 1);

    // Response backpressure on requester 2.
    do_reset();
    lat = 2;
    rsp_ready = 4'b1011;
    set_op(2, 16'd200, 16'd9);
    set_op(0, 16'd100, 16'd7);
    req_valid = 4'b0100;
    c = 0;
    @(negedge clock);
    while (rsp_valid == 0 && c < 40) begin
      if (req_ready != 0) begin
        step();
        req_valid = '0;
      end
      @(negedge clock);
      c++;
    end
    step();
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", rsp_valid, 4'b0100);
      chk("bp_q", rsp_quotient, 16'd22);
      chk("bp_r", rsp_remainder, 16'd2);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_no_start", div_start, 0);
      step();
    end
    rsp_ready = '1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_resume", req_ready, 4'b0001);
    step();
    req_valid = '0;
    c = 0;
    @(negedge clock);
    while (rsp_valid == 0 && c < 40) begin
      @(negedge clock);
      c++;
    end
    chk("bp_next_valid", rsp_valid, 4'b0001);
    chk("bp_next_q", rsp_quotient, 16'd14);

    // Reset while waiting for the divider.
    step();
    lat = 10;
    set_op(1, 16'd30, 16'd4);
    req_valid = 4'b0010;
    c = 0;
    @(negedge clock);
    while (req_ready == 0 && c < 20) begin
      @(negedge clock);
      c++;
    end
    step();
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk_zero("wait_reset_outs");
    step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stray_done_rsp", rsp_valid, 0);
      chk("stray_done_busy", busy, 0);
    end
    step();
    req_valid = 4'b1111;
    @(negedge clock);
    chk("reset_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
